// File: rtl/alu_shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package pkg_bits;

    localparam int BITS_WIDTH = 4;
    localparam int NUM_REQ    = 2;

    typedef logic [BITS_WIDTH-1:0] bits_t;
    typedef logic [BITS_WIDTH:0]   bitsw_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // One-hot vector selecting a single requester.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_shift_arbiter_if.sv
// Request/response channels between the operand sources and the arbiter.
interface alu_shift_arbiter_if #(
    parameter int BITS_WIDTH = pkg_bits::BITS_WIDTH
) ();

    logic [pkg_bits::NUM_REQ-1:0]                 req_valid_i;
    logic [pkg_bits::NUM_REQ-1:0]                 req_ready_o;
    logic [pkg_bits::NUM_REQ-1:0][BITS_WIDTH-1:0] req_a_i;
    logic [pkg_bits::NUM_REQ-1:0][BITS_WIDTH-1:0] req_b_i;
    logic [pkg_bits::NUM_REQ-1:0]                 req_flag_i;
    logic [pkg_bits::NUM_REQ-1:0]                 rsp_valid_o;
    logic [pkg_bits::NUM_REQ-1:0]                 rsp_ready_i;
    logic [BITS_WIDTH:0]                          rsp_data_o;
    logic                                         rsp_sat_o;

    // Operand sources side.
    modport master (
        output req_valid_i, req_a_i, req_b_i, req_flag_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_sat_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_flag_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_sat_o
    );

endinterface

// File: rtl/alu_shift_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// and under contention the requester that was not granted last wins.
module rr_arbiter2
    import pkg_bits::*;
(
    input  logic [1:0] valid_i,
    input  req_idx_t   last_i,
    output logic [1:0] gnt_o
);

    // Pick the winner from the valid vector and the last-grant pointer.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves gnt_o unassigned (which would infer a latch).
        gnt_o = 2'b00;
        case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == 1'b1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_shift_arbiter.sv
// Shares one external combinational right shifter between two requesters.
// Flow: IDLE accepts the round-robin winner and registers its operands onto
// the shifter, ISSUE captures the shifter result, RESP holds it until the
// granted requester takes it.
module alu_shift_arbiter #(
    parameter int BITS_WIDTH = pkg_bits::BITS_WIDTH,
    parameter int CNT_WIDTH  = 8,
    parameter bit CLAMP_EN   = 1'b1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    alu_shift_arbiter_if.slave                           bus,
    output logic [BITS_WIDTH-1:0]                        shf_a_o,
    output logic [BITS_WIDTH-1:0]                        shf_b_o,
    output logic                                         shf_flag_o,
    input  logic [BITS_WIDTH:0]                          shf_result_i,
    output logic                                         busy_o,
    output logic [pkg_bits::NUM_REQ-1:0][CNT_WIDTH-1:0]  gnt_cnt_o
);

    import pkg_bits::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_RESP  = RESP;

    // Largest shift that still means something for a BITS_WIDTH operand.
    localparam logic [BITS_WIDTH-1:0] B_MAX = BITS_WIDTH'(BITS_WIDTH);

    logic [1:0]                          state_q, state_d;
    req_idx_t                            ptr_q, ptr_d;
    req_idx_t                            win_q, win_d;
    logic [BITS_WIDTH-1:0]               shf_a_q, shf_a_d;
    logic [BITS_WIDTH-1:0]               shf_b_q, shf_b_d;
    logic                                shf_flag_q, shf_flag_d;
    logic                                sat_q, sat_d;
    logic [NUM_REQ-1:0]                  rsp_valid_q, rsp_valid_d;
    logic [BITS_WIDTH:0]                 rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0]                  gnt;
    req_idx_t                            win_idx;
    logic [BITS_WIDTH-1:0]               a_sel;
    logic [BITS_WIDTH-1:0]               b_sel;
    logic                                flag_sel;
    logic [BITS_WIDTH-1:0]               b_eff;
    logic                                sat_eff;

    rr_arbiter2 u_rr (
        .valid_i (bus.req_valid_i),
        .last_i  (ptr_q),
        .gnt_o   (gnt)
    );

    // Select the winner's operands and apply the optional shift-amount clamp.
    always_comb begin
        win_idx  = gnt[1];
        a_sel    = bus.req_a_i[win_idx];
        b_sel    = bus.req_b_i[win_idx];
        flag_sel = bus.req_flag_i[win_idx];
        b_eff    = b_sel;
        sat_eff  = 1'b0;
        if (CLAMP_EN && (b_sel > B_MAX)) begin
            b_eff   = B_MAX;
            sat_eff = 1'b1;
        end
    end

    // Next-state logic for the FSM and every register it controls.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        shf_a_d     = shf_a_q;
        shf_b_d     = shf_b_q;
        shf_flag_d  = shf_flag_q;
        sat_d       = sat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    shf_a_d    = a_sel;
                    shf_b_d    = b_eff;
                    shf_flag_d = flag_sel;
                    sat_d      = sat_eff;
                    win_d      = win_idx;
                    ptr_d      = win_idx;
                    if (cnt_q[win_idx] != {CNT_WIDTH{1'b1}}) begin
                        cnt_d[win_idx] = cnt_q[win_idx] + CNT_WIDTH'(1);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rsp_data_d  = shf_result_i;
                rsp_valid_d = idx_to_onehot(win_q);
                state_d     = S_RESP;
            end
            S_RESP: begin
                // Only the granted requester can complete the response.
                if (bus.rsp_ready_i[win_q]) begin
                    rsp_valid_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset drops any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b1;
            win_q       <= 1'b0;
            shf_a_q     <= '0;
            shf_b_q     <= '0;
            shf_flag_q  <= 1'b0;
            sat_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            shf_a_q     <= shf_a_d;
            shf_b_q     <= shf_b_d;
            shf_flag_q  <= shf_flag_d;
            sat_q       <= sat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready_o = (state_q == S_IDLE) ? gnt : '0;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_sat_o   = sat_q;
    assign shf_a_o         = shf_a_q;
    assign shf_b_o         = shf_b_q;
    assign shf_flag_o      = shf_flag_q;
    assign busy_o          = (state_q != S_IDLE);
    assign gnt_cnt_o       = cnt_q;

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed bench for alu_shift_arbiter with a behavioural right shifter.
module tb_alu_shift_arbiter;

    logic            clk;
    logic            rst_n;
    logic [3:0]      shf_a;
    logic [3:0]      shf_b;
    logic            shf_flag;
    logic [4:0]      shf_result;
    logic            busy;
    logic [1:0][7:0] gnt_cnt;

    int checks;
    int failures;

    alu_shift_arbiter_if #(.BITS_WIDTH(4)) bus ();

    alu_shift_arbiter #(
        .BITS_WIDTH (4),
        .CNT_WIDTH  (8),
        .CLAMP_EN   (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .bus          (bus),
        .shf_a_o      (shf_a),
        .shf_b_o      (shf_b),
        .shf_flag_o   (shf_flag),
        .shf_result_i (shf_result),
        .busy_o       (busy),
        .gnt_cnt_o    (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter: result = A >> B with fill bits = flag, carry = A[B-1] (0 for B = 0).
    function automatic logic [4:0] shift_model(input logic [3:0] a, input logic [3:0] b,
                                               input logic f);
        logic [4:0] r;
        int idx;
        int bi;
        bi = int'(b);
        for (int i = 0; i < 4; i++) begin
            idx  = i + bi;
            r[i] = (idx < 4) ? a[idx] : f;
        end
        r[4] = (bi == 0 || bi > 4) ? 1'b0 : a[bi-1];
        return r;
    endfunction

    always_comb shf_result = shift_model(shf_a, shf_b, shf_flag);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.req_valid_i    = 2'b00;
        bus.req_a_i        = '0;
        bus.req_b_i        = '0;
        bus.req_flag_i     = 2'b00;
        bus.rsp_ready_i    = 2'b00;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks += 6;
        if (bus.req_ready_o !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready_o); end
        if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
        if (bus.rsp_data_o !== 5'b0 || bus.rsp_sat_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_data got=%b/%b exp=00000/0", bus.rsp_data_o, bus.rsp_sat_o); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (shf_a !== 4'b0 || shf_b !== 4'b0 || shf_flag !== 1'b0) begin failures++; $display("FAIL reset_shf got=%b/%b/%b exp=0000/0000/0", shf_a, shf_b, shf_flag); end
        if (gnt_cnt !== 16'h0) begin failures++; $display("FAIL reset_gnt_cnt got=%h exp=0000", gnt_cnt); end
    endtask

    // One isolated operation on requester r with rsp_ready held high.
    task automatic run_op(input string name, input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic f, input logic [4:0] exp_data, input logic [3:0] exp_b,
                          input logic exp_sat);
        logic [1:0] oh;
        oh                 = 2'b01 << r;
        bus.req_a_i[r]     = a;
        bus.req_b_i[r]     = b;
        bus.req_flag_i[r]  = f;
        bus.rsp_ready_i    = 2'b11;
        bus.req_valid_i    = oh;
        #1;
        checks++;
        if (bus.req_ready_o !== oh) begin failures++; $display("FAIL %s_req_ready got=%b exp=%b", name, bus.req_ready_o, oh); end
        next_cycle();
        bus.req_valid_i = 2'b00;
        #1;
        checks += 3;
        if (busy !== 1'b1) begin failures++; $display("FAIL %s_issue_busy got=%b exp=1", name, busy); end
        if (shf_a !== a || shf_b !== exp_b || shf_flag !== f) begin failures++; $display("FAIL %s_shf got=%b/%b/%b exp=%b/%b/%b", name, shf_a, shf_b, shf_flag, a, exp_b, f); end
        if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL %s_issue_rsp_valid got=%b exp=00", name, bus.rsp_valid_o); end
        next_cycle();
        #1;
        checks += 3;
        if (bus.rsp_valid_o !== oh) begin failures++; $display("FAIL %s_rsp_valid got=%b exp=%b", name, bus.rsp_valid_o, oh); end
        if (bus.rsp_data_o !== exp_data) begin failures++; $display("FAIL %s_rsp_data got=%b exp=%b", name, bus.rsp_data_o, exp_data); end
        if (bus.rsp_sat_o !== exp_sat) begin failures++; $display("FAIL %s_rsp_sat got=%b exp=%b", name, bus.rsp_sat_o, exp_sat); end
        next_cycle();
        #1;
        checks++;
        if (bus.rsp_valid_o !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL %s_done got=%b/%b exp=00/0", name, bus.rsp_valid_o, busy); end
    endtask

    task automatic test_single();
        run_op("single", 0, 4'b1011, 4'd1, 1'b0, 5'b1_0101, 4'd1, 1'b0);
        checks++;
        if (gnt_cnt[0] !== 8'd1 || gnt_cnt[1] !== 8'd0) begin failures++; $display("FAIL single_gnt_cnt got=%0d/%0d exp=1/0", gnt_cnt[0], gnt_cnt[1]); end
    endtask

    task automatic test_ones_fill();
        run_op("ones_fill", 1, 4'b0010, 4'd2, 1'b1, 5'b1_1100, 4'd2, 1'b0);
        checks++;
        if (gnt_cnt[1] !== 8'd1) begin failures++; $display("FAIL ones_fill_gnt_cnt got=%0d exp=1", gnt_cnt[1]); end
    endtask

    task automatic test_clamp();
        run_op("clamp", 0, 4'b1111, 4'd9, 1'b0, 5'b1_0000, 4'd4, 1'b1);
        run_op("b_eq_width", 1, 4'b1000, 4'd4, 1'b1, 5'b1_1111, 4'd4, 1'b0);
        run_op("b_zero", 0, 4'b1010, 4'd0, 1'b1, 5'b0_1010, 4'd0, 1'b0);
    endtask

    task automatic test_contention();
        logic [1:0] exp_oh;
        rst_n = 1'b0;
        bus.req_valid_i = 2'b00;
        next_cycle();
        rst_n = 1'b1;
        bus.req_a_i[0]    = 4'b1011;
        bus.req_b_i[0]    = 4'd1;
        bus.req_flag_i[0] = 1'b0;
        bus.req_a_i[1]    = 4'b0010;
        bus.req_b_i[1]    = 4'd2;
        bus.req_flag_i[1] = 1'b1;
        bus.rsp_ready_i   = 2'b11;
        bus.req_valid_i   = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (bus.req_ready_o !== exp_oh) begin failures++; $display("FAIL contention_grant[%0d] got=%b exp=%b", i, bus.req_ready_o, exp_oh); end
            next_cycle();
            next_cycle();
            #1;
            checks += 2;
            if (bus.rsp_valid_o !== exp_oh) begin failures++; $display("FAIL contention_rsp_valid[%0d] got=%b exp=%b", i, bus.rsp_valid_o, exp_oh); end
            if (bus.rsp_data_o !== ((i % 2 == 0) ? 5'b1_0101 : 5'b1_1100)) begin failures++; $display("FAIL contention_rsp_data[%0d] got=%b", i, bus.rsp_data_o); end
            next_cycle();
        end
        bus.req_valid_i = 2'b00;
        #1;
        checks++;
        if (gnt_cnt[0] !== 8'd3 || gnt_cnt[1] !== 8'd3) begin failures++; $display("FAIL contention_gnt_cnt got=%0d/%0d exp=3/3", gnt_cnt[0], gnt_cnt[1]); end
    endtask

    task automatic test_backpressure();
        bus.req_a_i[0]    = 4'b0110;
        bus.req_b_i[0]    = 4'd0;
        bus.req_flag_i[0] = 1'b0;
        bus.rsp_ready_i   = 2'b10;
        bus.req_valid_i   = 2'b01;
        #1;
        checks++;
        if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", bus.req_ready_o); end
        next_cycle();
        bus.req_valid_i = 2'b11;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 3;
            if (bus.rsp_valid_o !== 2'b01) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=01", i, bus.rsp_valid_o); end
            if (bus.rsp_data_o !== 5'b0_0110) begin failures++; $display("FAIL bp_rsp_data[%0d] got=%b exp=00110", i, bus.rsp_data_o); end
            if (bus.req_ready_o !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b/%b exp=00/1", i, bus.req_ready_o, busy); end
            next_cycle();
        end
        bus.rsp_ready_i = 2'b01;
        #1;
        checks++;
        if (bus.rsp_valid_o !== 2'b01) begin failures++; $display("FAIL bp_pre_release got=%b exp=01", bus.rsp_valid_o); end
        next_cycle();
        #1;
        checks += 2;
        if (busy !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/00", busy, bus.rsp_valid_o); end
        if (bus.req_ready_o !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", bus.req_ready_o); end
        bus.req_valid_i = 2'b00;
    endtask

    task automatic test_reset_mid_resp();
        bus.req_a_i[1]    = 4'b1000;
        bus.req_b_i[1]    = 4'd4;
        bus.req_flag_i[1] = 1'b0;
        bus.rsp_ready_i   = 2'b00;
        next_cycle();
        bus.req_valid_i   = 2'b10;
        next_cycle();
        bus.req_valid_i = 2'b11;
        next_cycle();
        #1;
        checks++;
        if (bus.rsp_valid_o !== 2'b10 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b/%b exp=10/1", bus.rsp_valid_o, busy); end
        #2;
        bus.req_valid_i = 2'b00;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.rsp_valid_o !== 2'b00 || bus.req_ready_o !== 2'b00) begin failures++; $display("FAIL rst_mid_valid got=%b/%b exp=00/00", bus.rsp_valid_o, bus.req_ready_o); end
        if (bus.rsp_data_o !== 5'b0 || bus.rsp_sat_o !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_data got=%b/%b/%b exp=00000/0/0", bus.rsp_data_o, bus.rsp_sat_o, busy); end
        if (shf_a !== 4'b0 || shf_b !== 4'b0 || shf_flag !== 1'b0) begin failures++; $display("FAIL rst_mid_shf got=%b/%b/%b exp=0000/0000/0", shf_a, shf_b, shf_flag); end
        if (gnt_cnt !== 16'h0) begin failures++; $display("FAIL rst_mid_gnt_cnt got=%h exp=0000", gnt_cnt); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        bus.rsp_ready_i = 2'b11;
        bus.req_valid_i = 2'b11;
        #1;
        checks++;
        if (bus.req_ready_o !== 2'b01) begin failures++; $display("FAIL rst_mid_first_grant got=%b exp=01", bus.req_ready_o); end
        bus.req_valid_i = 2'b00;
        next_cycle();
        #1;
        checks++;
        if (bus.rsp_valid_o !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp got=%b/%b exp=00/0", bus.rsp_valid_o, busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_ones_fill();
        test_clamp();
        test_contention();
        test_backpressure();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
